// File: rtl/tnoc_vc_arbiter.sv
// Output-link arbiter for CHANNELS virtual channels: round-robin between packets,
// wormhole lock inside a packet, per-VC downstream credit counters.
module tnoc_vc_arbiter #(
    parameter int  CHANNELS = 2,
    parameter int  CREDITS  = 4,
    localparam int VC_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W    = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] vc_valid,
    input  logic [CHANNELS-1:0] vc_head,
    input  logic [CHANNELS-1:0] vc_tail,
    output logic [CHANNELS-1:0] vc_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [VC_W-1:0]     out_vc,
    input  logic [CHANNELS-1:0] credit_return,
    output logic [CHANNELS-1:0] vc_available,
    output logic                credit_error
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [VC_W-1:0]     rr_ptr;
    logic [VC_W-1:0]     lock_vc;
    logic [VC_W-1:0]     last_vc;
    logic [CNT_W-1:0]    credit_cnt [CHANNELS];

    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] overflow;
    logic                grant_found;
    logic [VC_W-1:0]     grant_idx;
    logic [VC_W-1:0]     next_ptr;
    logic                xfer;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            vc_available[i] = (credit_cnt[i] != '0);
            overflow[i]     = credit_return[i] & ~vc_ready[i] &
                              (credit_cnt[i] == CNT_W'(CREDITS));
        end
        eligible = vc_valid & vc_available;
    end

    // Scan offsets from the top down so the lowest offset from rr_ptr wins last.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (state == LOCKED) begin
            grant_found = eligible[lock_vc];
            grant_idx   = lock_vc;
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (eligible[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = VC_W'(idx);
                end
            end
        end
    end

    // Gating with rst_n keeps the link quiet while reset is held.
    assign out_valid = grant_found & rst_n;
    assign xfer      = out_valid & out_ready;
    assign vc_ready  = xfer ? (CHANNELS'(1) << grant_idx) : '0;
    assign out_vc    = out_valid ? grant_idx : last_vc;
    assign next_ptr  = (grant_idx == VC_W'(CHANNELS - 1)) ? '0 : grant_idx + VC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_vc <= '0;
            last_vc <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (out_valid) last_vc <= grant_idx;
            if (xfer) begin
                if (vc_tail[grant_idx]) begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                end else if (state == IDLE && vc_head[grant_idx]) begin
                    state   <= LOCKED;
                    lock_vc <= grant_idx;
                end
            end
        end
    end

    // A transfer and a credit return in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is real state, so every entry is reset, not left to power-up.
            for (int i = 0; i < CHANNELS; i++) credit_cnt[i] <= CNT_W'(CREDITS);
            credit_error <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (vc_ready[i] && !credit_return[i])
                    credit_cnt[i] <= credit_cnt[i] - CNT_W'(1);
                else if (credit_return[i] && !vc_ready[i] && !overflow[i])
                    credit_cnt[i] <= credit_cnt[i] + CNT_W'(1);
            end
            credit_error <= |overflow;
        end
    end

endmodule

// File: tb/tb_tnoc_vc_arbiter.sv
// Self-checking bench for tnoc_vc_arbiter: directed scenarios with literal
// expectations, then randomized packet traffic against a behavioural model.
module tb_tnoc_vc_arbiter;

    localparam int CH = 2;
    localparam int CR = 4;
    localparam int VW = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] vc_valid, vc_head, vc_tail, vc_ready;
    logic          out_valid, out_ready;
    logic [VW-1:0] out_vc;
    logic [CH-1:0] credit_return, vc_available;
    logic          credit_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tnoc_vc_arbiter #(.CHANNELS(CH), .CREDITS(CR)) dut (
        .clk(clk), .rst_n(rst_n),
        .vc_valid(vc_valid), .vc_head(vc_head), .vc_tail(vc_tail),
        .vc_ready(vc_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_vc(out_vc), .credit_return(credit_return),
        .vc_available(vc_available), .credit_error(credit_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credits as integers, lock as a flag, pointer as an integer.
    int m_cnt [CH];
    bit m_locked;
    int m_lock, m_ptr, m_last, m_xfer;
    bit m_err;

    function automatic int exp_grant();
        if (m_locked) return (vc_valid[m_lock] && m_cnt[m_lock] > 0) ? m_lock : -1;
        for (int k = 0; k < CH; k++) begin
            int i;
            i = (m_ptr + k) % CH;
            if (vc_valid[i] && m_cnt[i] > 0) return i;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) m_cnt[i] = CR;
            m_locked = 0; m_lock = 0; m_ptr = 0; m_last = 0; m_err = 0; m_xfer = -1;
        end else begin
            int g;
            bit x, ovf;
            g   = exp_grant();
            x   = (g >= 0) && out_ready;
            ovf = 0;
            for (int i = 0; i < CH; i++) begin
                bit tr;
                tr = x && (g == i);
                if (tr && !credit_return[i]) m_cnt[i]--;
                else if (credit_return[i] && !tr) begin
                    if (m_cnt[i] == CR) ovf = 1;
                    else m_cnt[i]++;
                end
            end
            m_err = ovf;
            if (g >= 0) m_last = g;
            if (x) begin
                if (vc_tail[g]) begin
                    m_ptr    = (g + 1) % CH;
                    m_locked = 0;
                end else if (vc_head[g] && !m_locked) begin
                    m_locked = 1;
                    m_lock   = g;
                end
            end
            m_xfer = x ? g : -1;
        end
    end

    // Compare process: every cycle, all outputs against the model.
    initial forever begin
        int g;
        logic [CH-1:0] e_rdy, e_av;
        logic [VW-1:0] e_vc;
        @(negedge clk);
        g     = rst_n ? exp_grant() : -1;
        e_rdy = ((g >= 0) && out_ready) ? CH'(1) << g : '0;
        e_vc  = (g >= 0) ? VW'(g) : VW'(m_last);
        for (int i = 0; i < CH; i++) e_av[i] = (m_cnt[i] != 0);
        check("model", 32'({out_valid, vc_ready, out_vc, vc_available, credit_error}),
                       32'({g >= 0, e_rdy, e_vc, e_av, m_err}));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] h,
                         input logic [CH-1:0] t, input logic [CH-1:0] cr);
        vc_valid = v; vc_head = h; vc_tail = t; credit_return = cr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 2'b11, 2'b00);
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_vc_ready", 32'(vc_ready), 32'd0);
        check("rst_out_vc", 32'(out_vc), 32'd0);
        check("rst_available", 32'(vc_available), 32'b11);
        check("rst_credit_error", 32'(credit_error), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    int rem [CH];
    bit first [CH];

    initial begin
        logic [3:0] alt;
        rst_n = 1'b1; out_ready = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        #2;
        do_reset();

        // Back-to-back single-flit packets alternate between VCs.
        alt = 4'b1010;
        drive(2'b11, 2'b11, 2'b11, 2'b00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("alt_out_vc", 32'(out_vc), 32'(alt[c]));
            check("alt_ready", 32'(vc_ready), 32'(c % 2 == 0 ? 2'b01 : 2'b10));
            tick();
        end
        do_reset();

        // 3-flit packet on VC0 holds the link while VC1 waits.
        for (int c = 0; c < 4; c++) begin
            drive(c < 3 ? 2'b11 : 2'b10, c == 0 ? 2'b11 : 2'b10, c == 2 ? 2'b11 : 2'b10, 2'b00);
            @(negedge clk);
            check("lock_out_vc", 32'(out_vc), c < 3 ? 32'd0 : 32'd1);
            tick();
        end
        do_reset();

        // Credit exhaustion on VC0, then a single returned credit.
        for (int c = 0; c < 7; c++) begin
            drive(2'b01, 2'b01, 2'b01, c == 4 ? 2'b01 : 2'b00);
            @(negedge clk);
            check("credit_out_valid", 32'(out_valid), (c < 4 || c == 5) ? 32'd1 : 32'd0);
            if (c == 4) check("credit_avail0", 32'(vc_available), 32'b10);
            tick();
        end
        do_reset();

        // Simultaneous transfer and return, then an overflowing return.
        for (int c = 0; c < 8; c++) begin
            drive(c < 3 ? 2'b10 : 2'b00, 2'b10, 2'b10, (c >= 2 && c <= 5) ? 2'b10 : 2'b00);
            @(negedge clk);
            if (c < 3) check("ovf_out_vc", 32'(out_vc), 32'd1);
            if (c >= 5) check("ovf_credit_error", 32'(credit_error), c == 6 ? 32'd1 : 32'd0);
            tick();
        end
        do_reset();

        // Reset mid-packet while locked on VC1.
        drive(2'b10, 2'b10, 2'b00, 2'b00);
        @(negedge clk);
        check("midrst_head_vc", 32'(out_vc), 32'd1);
        tick();
        drive(2'b11, 2'b01, 2'b01, 2'b00);
        @(negedge clk);
        check("midrst_locked_vc", 32'(out_vc), 32'd1);
        tick();
        do_reset();
        drive(2'b11, 2'b11, 2'b11, 2'b00);
        @(negedge clk);
        check("midrst_first_grant", 32'(vc_ready), 32'b01);
        tick();
        do_reset();

        // Locked VC0 runs dry; VC1 must not slip in mid-packet.
        for (int c = 0; c < 7; c++) begin
            drive(2'b11, c == 0 ? 2'b11 : 2'b10, 2'b10, c == 5 ? 2'b01 : 2'b00);
            @(negedge clk);
            check("dry_out_valid", 32'(out_valid), (c == 4 || c == 5) ? 32'd0 : 32'd1);
            if (c == 6) check("dry_out_vc", 32'(out_vc), 32'd0);
            tick();
        end
        do_reset();

        // Randomized packet traffic; valid is held until each flit transfers.
        for (int i = 0; i < CH; i++) begin rem[i] = 0; first[i] = 0; end
        repeat (3000) begin
            for (int i = 0; i < CH; i++) begin
                if (m_xfer == i) begin rem[i]--; first[i] = 0; end
                if (rem[i] == 0 && $urandom_range(3) == 0) begin
                    rem[i]   = int'($urandom_range(4, 1));
                    first[i] = ($urandom_range(9) != 0);
                end
                vc_valid[i]      = (rem[i] > 0);
                vc_head[i]       = first[i];
                vc_tail[i]       = (rem[i] == 1);
                credit_return[i] = ($urandom_range(9) < 3);
            end
            out_ready = ($urandom_range(3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnoc_vc_arbiter.md
TNOC_VC_ARBITER -- requirements
Module: tnoc_vc_arbiter

Interface
REQ-001 Parameter CHANNELS, default 2: number of virtual channels sharing one output link; legal range 1..8.
REQ-002 Parameter CREDITS, default 4: per-VC downstream buffer depth in flits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 vc_valid  input  CHANNELS  per-VC flit pending.
REQ-006 vc_head  input  CHANNELS  per-VC flag: pending flit is a head flit.
REQ-007 vc_tail  input  CHANNELS  per-VC flag: pending flit is a tail flit; head and tail may both be set for a single-flit packet.
REQ-008 vc_ready  output  CHANNELS  per-VC accept; one-hot or zero.
REQ-009 out_valid  output  1  flit presented on the link.
REQ-010 out_ready  input  1  link accepts the flit.
REQ-011 out_vc  output  clog2(CHANNELS), minimum 1 bit  index of the granted VC; drives the data mux.
REQ-012 credit_return  input  CHANNELS  one-cycle pulse per freed downstream buffer slot.
REQ-013 vc_available  output  CHANNELS  per-VC credit count nonzero.
REQ-014 credit_error  output  1  registered one-cycle pulse on a credit overflow.

Function
REQ-015 A transfer on VC i occurs in a cycle with out_valid, out_ready and vc_ready[i] all high.
REQ-016 Each VC has a credit counter, width clog2(CREDITS+1), reset value CREDITS.
REQ-017 Counter update per cycle: minus 1 on a transfer only; plus 1 on credit_return only; unchanged when both occur.
REQ-018 A credit_return to a counter already at CREDITS, with no same-cycle transfer, leaves the counter at CREDITS and pulses credit_error in the next cycle.
REQ-019 A VC is eligible when vc_valid[i] is set and its counter is nonzero; vc_available[i] equals (counter != 0).
REQ-020 FSM state IDLE: grant goes to the first eligible VC at or after rr_ptr, in increasing index order with wrap-around; rr_ptr resets to 0.
REQ-021 FSM state LOCKED: grant is held on lock_vc regardless of other requesters; out_valid is high only when lock_vc is eligible.
REQ-022 IDLE to LOCKED: on a transfer with head=1 and tail=0; lock_vc is loaded with the granted index.
REQ-023 LOCKED to IDLE: on a transfer of the tail flit of lock_vc.
REQ-024 rr_ptr is loaded with (granted index + 1) mod CHANNELS on each tail-flit transfer, in either state.
REQ-025 A single-flit packet (head=1, tail=1) in IDLE keeps the FSM in IDLE and advances rr_ptr.
REQ-026 Outputs are combinational from state and inputs, giving zero-cycle arbitration latency:
- out_valid = a grant exists
- vc_ready[g] = out_ready AND out_valid
- out_vc = g
REQ-027 With no grant, out_valid=0 and vc_ready=0, and out_vc holds its last registered value (0 after reset).
REQ-028 out_valid, once high, is not withdrawn while out_ready is low, because eligibility cannot drop without a transfer; upstream holds vc_valid until the transfer.
REQ-029 A non-head flit presented in IDLE is still arbitrated and transferred; the FSM stays in IDLE (error tolerance, no lock).
REQ-030 Credits are checked per VC only; a zero counter on one VC never blocks another VC in IDLE.

Reset
REQ-031 Asserting rst_n low, including mid-packet, immediately forces all of the following: FSM=IDLE, rr_ptr=0, lock_vc=0, out_vc=0, all counters=CREDITS, credit_error=0.
REQ-032 While in reset, out_valid=0 and vc_ready=0.
REQ-033 Deassertion takes effect synchronously to clk; the first grant is possible in the first cycle after release.

Verification
REQ-034 Defaults, out_ready=1; VC0 and VC1 each send 1-flit packets back to back -> grants alternate 0,1,0,1 with one transfer per cycle.
REQ-035 VC0 sends a 3-flit packet while VC1 is valid throughout -> out_vc=0 for three consecutive transfers, then VC1 is granted.
REQ-036 VC0 sends 5 single flits with no credit_return -> 4 transfers, then vc_available[0]=0 and out_valid=0; one credit_return[0] -> one more transfer.
REQ-037 Transfer and credit_return on VC1 in the same cycle at count 2 -> count stays 2; credit_return with count at 4 and no transfer -> count stays 4 and credit_error pulses once.
REQ-038 rst_n pulsed low in LOCKED after a head flit on VC1 -> FSM=IDLE, counters=4, rr_ptr=0; with both VCs valid after release, VC0 is granted first.
REQ-039 LOCKED on VC0 with VC0 counter at 0 and VC1 eligible -> out_valid=0 until a credit is returned to VC0; VC1 is not granted mid-packet.
